// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, op encoding and default widths.
package mem_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/ram_sp.sv
// Single-port word-addressed RAM; read data is registered only when a read is enabled,
// so it holds the last read word between accesses.
module ram_sp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  import mem_pkg::*;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // The array itself is never reset; only the read register is.
  always_ff @(posedge Clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts Read/Write strobe edges, waits WAIT_STATES cycles,
// performs one RAM access and pulses Mem_ready.
module mem_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = mem_pkg::DATA_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] MAR_addr,
  input  logic [DATA_W-1:0] MDR_wdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Mem_ready,
  output logic              Busy,
  output logic              Err
);
  import mem_pkg::*;

  state_t            state;
  op_t               op_q;
  logic              req;
  logic              req_prev;
  logic              start;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ram_we;
  logic              ram_re;

  // Only a rising edge of either strobe starts an access, so a held strobe never retriggers.
  assign req    = Read | Write;
  assign start  = req & ~req_prev;
  assign ram_we = (state == ACCESS) && (op_q == OP_WR);
  assign ram_re = (state == ACCESS) && (op_q == OP_RD);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      op_q      <= OP_RD;
      req_prev  <= 1'b0;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      Mem_ready <= 1'b0;
      Busy      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      req_prev  <= req;
      Mem_ready <= 1'b0;
      Err       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (Read ^ Write) begin
              addr_q  <= MAR_addr;
              wdata_q <= MDR_wdata;
              op_q    <= Write ? OP_WR : OP_RD;
              cnt     <= CNT_W'(WAIT_STATES);
              Busy    <= 1'b1;
              state   <= WAIT;
            end else begin
              Err <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= ACCESS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // The RAM commits the write or captures read data on this same edge.
        ACCESS: begin
          Mem_ready <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  ram_sp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .Clock (Clock),
    .Resetn(Resetn),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (Mdatain)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (WAIT_STATES 1, 0, 3) driven by
// directed vectors; a negedge monitor checks Mem_ready, Err, Busy and Mdatain every cycle.
module tb_mem_responder;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int N  = 3;

  typedef struct {
    int            cyc;
    bit            is_read;
    logic [DW-1:0] data;
  } exp_t;

  logic                   Clock  = 1'b0;
  logic                   Resetn = 1'b0;
  logic [N-1:0]           rd;
  logic [N-1:0]           wr;
  logic [N-1:0][AW-1:0]   mar;
  logic [N-1:0][DW-1:0]   mdr;
  wire  [N-1:0][DW-1:0]   mdat;
  wire  [N-1:0]           rdy;
  wire  [N-1:0]           busy;
  wire  [N-1:0]           err;

  int            cyc    = 0;
  int            checks = 0;
  int            errors = 0;
  exp_t          rdy_q     [N][$];
  int            err_q     [N][$];
  int            busy_from [N];
  int            busy_to   [N];
  logic [DW-1:0] exp_mdat  [N];

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(1)) u_w1 (
    .Clock(Clock), .Resetn(Resetn), .Read(rd[0]), .Write(wr[0]),
    .MAR_addr(mar[0]), .MDR_wdata(mdr[0]), .Mdatain(mdat[0]),
    .Mem_ready(rdy[0]), .Busy(busy[0]), .Err(err[0])
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(0)) u_w0 (
    .Clock(Clock), .Resetn(Resetn), .Read(rd[1]), .Write(wr[1]),
    .MAR_addr(mar[1]), .MDR_wdata(mdr[1]), .Mdatain(mdat[1]),
    .Mem_ready(rdy[1]), .Busy(busy[1]), .Err(err[1])
  );

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(3)) u_w3 (
    .Clock(Clock), .Resetn(Resetn), .Read(rd[2]), .Write(wr[2]),
    .MAR_addr(mar[2]), .MDR_wdata(mdr[2]), .Mdatain(mdat[2]),
    .Mem_ready(rdy[2]), .Busy(busy[2]), .Err(err[2])
  );

  always #5 Clock = ~Clock;

  // cyc equals the number of rising edges seen; sampled at negedge it names the last edge.
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic clear_expect();
    for (int i = 0; i < N; i++) begin
      rdy_q[i].delete();
      err_q[i].delete();
      busy_from[i] = 1;
      busy_to[i]   = 0;
      exp_mdat[i]  = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Raises the strobes on a negedge so the next rising edge is the accept edge,
  // records what that access must produce, and drops the strobes after 'hold' cycles.
  task automatic applyStimulus(input int i, input logic r, input logic w,
                               input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [DW-1:0] exp_rd, input int hold);
    exp_t e;
    int   acc;
    @(negedge Clock);
    rd[i]  = r;
    wr[i]  = w;
    mar[i] = a;
    mdr[i] = d;
    acc    = cyc + 1;
    if (r && w) begin
      err_q[i].push_back(acc);
    end else begin
      e.cyc     = acc + ws_of(i) + 2;
      e.is_read = r;
      e.data    = exp_rd;
      rdy_q[i].push_back(e);
      busy_from[i] = acc;
      busy_to[i]   = acc + ws_of(i) + 2;
    end
    repeat (hold) @(negedge Clock);
    rd[i] = 1'b0;
    wr[i] = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    int   ec;
    logic exp_busy;
    forever begin
      @(negedge Clock);
      if (Resetn) begin
        for (int i = 0; i < N; i++) begin
          if (rdy[i]) begin
            if (rdy_q[i].size() == 0) begin
              checkOutput($sformatf("u%0d unexpected Mem_ready", i), DW'(rdy[i]), '0);
            end else begin
              e = rdy_q[i].pop_front();
              checkOutput($sformatf("u%0d Mem_ready cycle", i), DW'(cyc), DW'(e.cyc));
              if (e.is_read) exp_mdat[i] = e.data;
            end
          end else if (rdy_q[i].size() != 0 && rdy_q[i][0].cyc <= cyc) begin
            e = rdy_q[i].pop_front();
            checkOutput($sformatf("u%0d missing Mem_ready at %0d", i, e.cyc), DW'(rdy[i]), DW'(1));
          end

          if (err[i]) begin
            if (err_q[i].size() == 0) begin
              checkOutput($sformatf("u%0d unexpected Err", i), DW'(err[i]), '0);
            end else begin
              ec = err_q[i].pop_front();
              checkOutput($sformatf("u%0d Err cycle", i), DW'(cyc), DW'(ec));
            end
          end else if (err_q[i].size() != 0 && err_q[i][0] <= cyc) begin
            ec = err_q[i].pop_front();
            checkOutput($sformatf("u%0d missing Err at %0d", i, ec), DW'(err[i]), DW'(1));
          end

          exp_busy = (cyc >= busy_from[i]) && (cyc <= busy_to[i]);
          checkOutput($sformatf("u%0d Busy at %0d", i, cyc), DW'(busy[i]), DW'(exp_busy));
          checkOutput($sformatf("u%0d Mdatain at %0d", i, cyc), mdat[i], exp_mdat[i]);
        end
      end
    end
  end

  initial begin : stimulus
    rd  = '0;
    wr  = '0;
    mar = '0;
    mdr = '0;
    clear_expect();
    Resetn = 1'b0;
    idle(2);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("u%0d reset Mdatain", i), mdat[i], '0);
      checkOutput($sformatf("u%0d reset Mem_ready", i), DW'(rdy[i]), '0);
      checkOutput($sformatf("u%0d reset Busy", i), DW'(busy[i]), '0);
      checkOutput($sformatf("u%0d reset Err", i), DW'(err[i]), '0);
    end
    Resetn = 1'b1;
    idle(2);

    $display("[TB] write then read, WAIT_STATES=1");
    applyStimulus(0, 1'b0, 1'b1, 9'h055, 32'h1234_5678, '0, 1);
    idle(6);
    applyStimulus(0, 1'b1, 1'b0, 9'h055, '0, 32'h1234_5678, 1);
    idle(6);

    $display("[TB] reset aborts a pending write");
    applyStimulus(0, 1'b0, 1'b1, 9'h010, 32'h1111_1111, '0, 1);
    idle(6);
    applyStimulus(0, 1'b1, 1'b0, 9'h010, '0, 32'h1111_1111, 1);
    idle(6);
    applyStimulus(0, 1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF, '0, 1);
    Resetn = 1'b0;
    clear_expect();
    @(negedge Clock);
    checkOutput("mid-reset Mdatain", mdat[0], '0);
    checkOutput("mid-reset Mem_ready", DW'(rdy[0]), '0);
    checkOutput("mid-reset Busy", DW'(busy[0]), '0);
    checkOutput("mid-reset Err", DW'(err[0]), '0);
    @(negedge Clock);
    Resetn = 1'b1;
    idle(2);
    applyStimulus(0, 1'b1, 1'b0, 9'h010, '0, 32'h1111_1111, 1);
    idle(6);

    $display("[TB] latency with WAIT_STATES=0 and 3");
    applyStimulus(1, 1'b0, 1'b1, 9'h001, 32'hCAFE_0000, '0, 1);
    idle(6);
    applyStimulus(1, 1'b1, 1'b0, 9'h001, '0, 32'hCAFE_0000, 1);
    idle(6);
    applyStimulus(2, 1'b0, 1'b1, 9'h001, 32'hCAFE_0003, '0, 1);
    idle(8);
    applyStimulus(2, 1'b1, 1'b0, 9'h001, '0, 32'hCAFE_0003, 1);
    idle(8);

    $display("[TB] held read strobe");
    applyStimulus(0, 1'b0, 1'b1, 9'h020, 32'h0BAD_F00D, '0, 1);
    idle(6);
    applyStimulus(0, 1'b1, 1'b0, 9'h020, '0, 32'h0BAD_F00D, 10);
    idle(4);
    applyStimulus(0, 1'b1, 1'b0, 9'h020, '0, 32'h0BAD_F00D, 1);
    idle(6);

    $display("[TB] read/write conflict");
    applyStimulus(0, 1'b0, 1'b1, 9'h030, 32'h3030_3030, '0, 1);
    idle(6);
    applyStimulus(0, 1'b1, 1'b1, 9'h030, 32'hFFFF_FFFF, '0, 1);
    idle(6);
    applyStimulus(0, 1'b1, 1'b0, 9'h030, '0, 32'h3030_3030, 1);
    idle(6);

    $display("[TB] MAR/MDR changes and read edge while busy");
    applyStimulus(0, 1'b0, 1'b1, 9'h041, 32'h4141_4141, '0, 1);
    idle(6);
    applyStimulus(0, 1'b0, 1'b1, 9'h040, 32'hAAAA_0000, '0, 1);
    mar[0] = 9'h041;
    mdr[0] = 32'h0000_5555;
    @(negedge Clock);
    rd[0] = 1'b1;
    @(negedge Clock);
    rd[0] = 1'b0;
    idle(6);
    applyStimulus(0, 1'b1, 1'b0, 9'h040, '0, 32'hAAAA_0000, 1);
    idle(6);
    applyStimulus(0, 1'b1, 1'b0, 9'h041, '0, 32'h4141_4141, 1);
    idle(10);

    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("u%0d pending Mem_ready", i), DW'(rdy_q[i].size()), '0);
      checkOutput($sformatf("u%0d pending Err", i), DW'(err_q[i].size()), '0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
